// File: rtl/spi_fifo_master.sv
// SPI master with TX/RX FIFOs and per-frame CPOL/CPHA/bit-order/divider/slave-select.
// A frame starts only when RX has room, so a received word always has a slot waiting.
module spi_fifo_master #(
   parameter int DATA_WIDTH       = 8,
   parameter int FIFO_DEPTH       = 4,
   parameter int NUM_SLAVES       = 4,
   parameter bit SLAVE_ACTIVE_LOW = 1'b1,
   parameter int DIV_WIDTH        = 8,
   localparam int SS_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
   localparam int PTR_W = $clog2(FIFO_DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  lsb_first,
   input  logic [DIV_WIDTH-1:0]  clk_div,
   input  logic [SS_W-1:0]       ss_sel,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  sclk,
   output logic                  mosi,
   input  logic                  miso,
   output logic [NUM_SLAVES-1:0] ss_n,
   output logic                  busy,
   output logic                  irq,
   output logic [LVL_W-1:0]      tx_level,
   output logic [LVL_W-1:0]      rx_level
);
   localparam int ECW   = $clog2(2*DATA_WIDTH) + 1;
   localparam int IDX_W = $clog2(DATA_WIDTH);
   localparam logic [LVL_W-1:0] FULL      = LVL_W'(FIFO_DEPTH);
   localparam logic [ECW-1:0]   LAST_EDGE = ECW'(2*DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;
   state_t state, state_n;

   logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      tx_wr, tx_rd, rx_wr, rx_rd;
   logic [LVL_W-1:0]      tx_cnt, rx_cnt;
   logic                  tx_push, tx_pop, rx_push, rx_pop;
   logic [DATA_WIDTH-1:0] tx_head;

   logic [DIV_WIDTH-1:0]  cnt, div_q;
   logic                  cpol_q, cpha_q, lsb_q, sclk_q, mosi_q, ss_act, irq_q;
   logic [SS_W-1:0]       sel_q;
   logic [ECW-1:0]        edge_cnt, samp_n, drv_n;
   logic [DATA_WIDTH-1:0] txw, rxw;
   logic [IDX_W-1:0]      samp_idx, drv_idx;
   logic                  half_done, start, do_edge, finish, leading, do_samp, do_drv;

   // ---------------- FIFOs ----------------
   assign tx_ready = (tx_cnt != FULL);
   assign tx_push  = tx_valid && tx_ready;
   assign tx_pop   = start;
   assign tx_head  = tx_mem[tx_rd];
   assign rx_valid = (rx_cnt != '0);
   assign rx_pop   = rx_valid && rx_ready;
   assign rx_push  = finish && (rx_cnt != FULL);
   assign rx_data  = rx_mem[rx_rd];
   assign tx_level = tx_cnt;
   assign rx_level = rx_cnt;

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr] <= tx_data;
      if (rx_push) rx_mem[rx_wr] <= rxw;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wr  <= '0;
         tx_rd  <= '0;
         tx_cnt <= '0;
         rx_wr  <= '0;
         rx_rd  <= '0;
         rx_cnt <= '0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + PTR_W'(1);
         if (tx_pop)  tx_rd <= tx_rd + PTR_W'(1);
         if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + LVL_W'(1);
         else if (tx_pop && !tx_push) tx_cnt <= tx_cnt - LVL_W'(1);
         if (rx_push) rx_wr <= rx_wr + PTR_W'(1);
         if (rx_pop)  rx_rd <= rx_rd + PTR_W'(1);
         if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + LVL_W'(1);
         else if (rx_pop && !rx_push) rx_cnt <= rx_cnt - LVL_W'(1);
      end
   end

   // ---------------- frame FSM ----------------
   assign half_done = (cnt == div_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      start   = 1'b0;
      do_edge = 1'b0;
      finish  = 1'b0;
      case (state)
         IDLE:  if (tx_cnt != '0 && rx_cnt != FULL) begin start = 1'b1; state_n = LEAD; end
         LEAD:  if (half_done) begin do_edge = 1'b1; state_n = SHIFT; end
         SHIFT: if (half_done) begin
                   do_edge = 1'b1;
                   if (edge_cnt == LAST_EDGE) state_n = TRAIL;
                end
         TRAIL: if (half_done) begin finish = 1'b1; state_n = GAP; end
         GAP:   if (half_done) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Even edge index = leading edge; bit n is sampled/driven on edge 2n or 2n+1 by cpha.
   always_comb begin
      leading  = ~edge_cnt[0];
      samp_n   = edge_cnt >> 1;
      drv_n    = cpha_q ? samp_n : ((edge_cnt + ECW'(1)) >> 1);
      do_samp  = (leading != cpha_q);
      do_drv   = (leading == cpha_q) && (drv_n < ECW'(DATA_WIDTH));
      samp_idx = lsb_q ? samp_n[IDX_W-1:0] : IDX_W'(DATA_WIDTH-1) - samp_n[IDX_W-1:0];
      drv_idx  = lsb_q ? drv_n[IDX_W-1:0]  : IDX_W'(DATA_WIDTH-1) - drv_n[IDX_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         div_q    <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         lsb_q    <= 1'b0;
         sel_q    <= '0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         ss_act   <= 1'b0;
         irq_q    <= 1'b0;
         edge_cnt <= '0;
         txw      <= '0;
         rxw      <= '0;
      end else begin
         irq_q <= finish;
         cnt   <= (state == IDLE || half_done) ? '0 : cnt + DIV_WIDTH'(1);
         // Idle level tracks the live cpol; inside a frame only the latched copy counts.
         if (state == IDLE)       sclk_q <= cpol;
         else if (state == TRAIL) sclk_q <= cpol_q;
         else if (do_edge)        sclk_q <= ~sclk_q;
         if (start) begin
            div_q    <= clk_div;
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            lsb_q    <= lsb_first;
            sel_q    <= ss_sel;
            txw      <= tx_head;
            rxw      <= '0;
            edge_cnt <= '0;
            ss_act   <= 1'b1;
            mosi_q   <= lsb_first ? tx_head[0] : tx_head[DATA_WIDTH-1];
         end
         if (do_edge) begin
            edge_cnt <= edge_cnt + ECW'(1);
            if (do_samp) rxw[samp_idx] <= miso;
            if (do_drv)  mosi_q <= txw[drv_idx];
         end
         if (finish) ss_act <= 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_ss
      assign ss_n[i] = (ss_act && (sel_q == SS_W'(i))) ^ SLAVE_ACTIVE_LOW;
   end

   assign sclk = sclk_q;
   assign mosi = mosi_q;
   assign irq  = irq_q;
   assign busy = (state != IDLE);
endmodule

// File: tb/tb_spi_fifo_master.sv
// Bench for spi_fifo_master: frame-level SPI slave/monitor plus RX scoreboard.
// Each pushed word carries its expected config and slave reply; monitors compare independently.
module tb_spi_fifo_master;
   localparam int DW = 8, FD = 4, NS = 4, DVW = 8;

   logic clk = 1'b0, rst_n = 1'b0;
   logic cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
   logic [DVW-1:0] clk_div = '0;
   logic [1:0] ss_sel = '0;
   logic tx_valid = 1'b0, tx_ready;
   logic [DW-1:0] tx_data = '0;
   logic rx_valid, rx_ready;
   logic [DW-1:0] rx_data;
   logic sclk, mosi, miso;
   logic [NS-1:0] ss_n;
   logic busy, irq;
   logic [2:0] tx_level, rx_level;

   spi_fifo_master #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .NUM_SLAVES(NS),
                     .SLAVE_ACTIVE_LOW(1'b1), .DIV_WIDTH(DVW)) dut (
      .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
      .clk_div(clk_div), .ss_sel(ss_sel), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_data(tx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n), .busy(busy), .irq(irq),
      .tx_level(tx_level), .rx_level(rx_level));

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] tx;
      logic [DW-1:0] sw;
      logic cpol, cpha, lsb;
      int sel;
      int h;
   } frame_t;

   frame_t        frame_q[$];
   logic [DW-1:0] rx_exp_q[$];
   int checks = 0, errors = 0;
   int frames_done = 0, irq_cnt = 0;
   bit rx_hold = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Position in the data word of the n-th bit on the wire.
   function automatic int pos(input frame_t f, input int n);
      return f.lsb ? n : DW - 1 - n;
   endfunction

   function automatic logic sbit(input frame_t f, input int n);
      return f.sw[pos(f, n)];
   endfunction

   // Slave model and frame checker: reacts to ss/sclk as seen between clock edges.
   initial begin : frame_mon
      bit act;
      frame_t f;
      int edges, last_t, cyc, gap_start, nact, idx;
      logic sprev;
      logic [DW-1:0] mw;
      bit bad_sp;
      act = 0; cyc = 0; gap_start = -1000; miso = 1'b0;
      edges = 0; last_t = 0; sprev = 1'b0; mw = '0; bad_sp = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            act = 0;
            frame_q.delete();
            rx_exp_q.delete();
            miso = 1'b0;
            continue;
         end
         if (irq) irq_cnt++;
         nact = 0; idx = -1;
         for (int i = 0; i < NS; i++) if (ss_n[i] == 1'b0) begin nact++; idx = i; end
         if (nact > 1) check("ss_onehot", nact, 1);
         if (!act && nact == 1) begin
            act = 1;
            if (frame_q.size() == 0) begin
               check("frame_expected", 0, 1);
               f = '{tx: '0, sw: '0, cpol: 1'b0, cpha: 1'b0, lsb: 1'b0, sel: 0, h: 1};
            end else f = frame_q.pop_front();
            check("ss_line", idx, f.sel);
            check("ss_gap_ge_h", int'(cyc - gap_start >= f.h), 1);
            check("sclk_idle_start", sclk, f.cpol);
            rx_exp_q.push_back(f.sw);
            edges = 0; last_t = cyc; sprev = sclk; mw = '0; bad_sp = 0;
            miso = sbit(f, 0);
         end else if (act && nact == 1) begin
            if (sclk !== sprev) begin
               if (cyc - last_t != f.h) bad_sp = 1;
               last_t = cyc; sprev = sclk;
               if ((edges % 2 == 0) == (f.cpha == 1'b0) && edges / 2 < DW) mw[pos(f, edges / 2)] = mosi;
               if (f.cpha == 1'b0 && edges % 2 == 1 && (edges + 1) / 2 < DW) miso = sbit(f, (edges + 1) / 2);
               if (f.cpha == 1'b1 && edges % 2 == 0 && edges / 2 < DW) miso = sbit(f, edges / 2);
               edges++;
            end
         end else if (act && nact == 0) begin
            act = 0; frames_done++; gap_start = cyc;
            check("sclk_edges", edges, 2 * DW);
            check("edge_spacing_bad", bad_sp, 0);
            check("trail_len", cyc - last_t, f.h);
            check("mosi_word", mw, f.tx);
            check("sclk_idle_end", sclk, f.cpol);
            check("irq_at_frame_end", irq, 1);
         end
      end
   end

   // RX consumer / scoreboard: picks rx_ready, then checks the pop it commits to.
   initial begin : rx_mon
      rx_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin rx_ready = 1'b0; continue; end
         rx_ready = !rx_hold && ($urandom_range(0, 3) != 0);
         if (rx_valid && rx_ready) begin
            if (rx_exp_q.size() == 0) check("rx_unexpected", 1, 0);
            else check("rx_data", rx_data, rx_exp_q.pop_front());
         end
      end
   end

   task automatic push(input logic [DW-1:0] d, input logic [DW-1:0] s, output int stall);
      frame_t f;
      @(negedge clk);
      tx_valid = 1'b1; tx_data = d; stall = 0;
      while (!tx_ready && stall < 5000) begin @(negedge clk); stall++; end
      if (!tx_ready) begin
         check("tx_push_timeout", 0, 1);
         tx_valid = 1'b0;
         return;
      end
      f.tx = d; f.sw = s; f.cpol = cpol; f.cpha = cpha; f.lsb = lsb_first;
      f.sel = int'(ss_sel); f.h = int'(clk_div) + 1;
      frame_q.push_back(f);
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin @(negedge clk); n++; end
      while (!(!busy && tx_level == 0 && !rx_valid && frame_q.size() == 0) && n < 20000);
      if (n >= 20000) check("idle_timeout", 0, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_busy();
      int n = 0;
      while (!busy && n < 200) begin @(negedge clk); n++; end
      if (!busy) check("busy_timeout", 0, 1);
   endtask

   task automatic set_cfg(input logic p, input logic h, input logic l, input int sel, input int div);
      cpol = p; cpha = h; lsb_first = l; ss_sel = 2'(sel); clk_div = DVW'(div);
   endtask

   initial begin : stim
      int st, fd0, n;
      logic s_prev;
      repeat (3) @(negedge clk);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_ss_n", int'(ss_n), 4'hF);
      check("rst_busy", busy, 0);
      check("rst_irq", irq, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_levels", int'(tx_level) + int'(rx_level), 0);
      rst_n = 1'b1;

      // mode 0, H = 2, loopback-equivalent slave reply
      set_cfg(0, 0, 0, 0, 1);
      push(8'hA5, 8'hA5, st);
      wait_idle();

      // modes 1..3, LSB first, slave replies 0xC3
      for (int m = 1; m < 4; m++) begin
         set_cfg(m[1], m[0], 1, 1, 0);
         push(8'h3C, 8'hC3, st);
         wait_idle();
         check("sclk_idle_cpol", sclk, cpol);
      end

      // TX full: primer frame then 5 pushes; the 5th must stall
      set_cfg(0, 1, 0, 3, 2);
      push(8'h11, 8'hEE, st);
      wait_busy();
      for (int i = 0; i < 4; i++) push(DW'($urandom), DW'($urandom), st);
      check("tx_full_level", tx_level, 4);
      check("tx_ready_full", tx_ready, 0);
      push(8'h55, 8'hAA, st);
      check("tx_5th_stalled", int'(st > 0), 1);
      wait_idle();

      // RX full blocks the next frame
      set_cfg(1, 0, 0, 0, 0);
      rx_hold = 1'b1;
      @(negedge clk);
      fd0 = frames_done;
      for (int i = 0; i < 5; i++) push(DW'($urandom), DW'($urandom), st);
      repeat (300) @(negedge clk);
      check("rxfull_frames", frames_done - fd0, 4);
      check("rxfull_busy", busy, 0);
      check("rxfull_tx_level", tx_level, 1);
      check("rxfull_rx_level", rx_level, 4);
      rx_hold = 1'b0;
      wait_idle();
      check("rxfull_frames_after_pop", frames_done - fd0, 5);

      // config change mid-frame affects only the next frame
      set_cfg(0, 0, 0, 2, 2);
      push(8'h96, 8'h5A, st);
      wait_busy();
      repeat (4) @(negedge clk);
      cpol = 1'b1; ss_sel = 2'd1;
      push(8'h0F, 8'hF0, st);
      wait_idle();

      // randomized batches
      for (int b = 0; b < 8; b++) begin
         set_cfg(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) push(DW'($urandom), DW'($urandom), st);
         wait_idle();
      end

      // reset mid-frame at edge 7
      set_cfg(1, 0, 0, 3, 1);
      push(8'hC6, 8'h39, st);
      wait_busy();
      fd0 = irq_cnt; n = 0; st = 0; s_prev = sclk;
      while (n < 7 && st < 1000) begin
         @(negedge clk); st++;
         if (sclk !== s_prev) begin n++; s_prev = sclk; end
      end
      check("reached_edge7", n, 7);
      #2 rst_n = 1'b0;
      #1;
      check("abort_ss_n", int'(ss_n), 4'hF);
      check("abort_busy", busy, 0);
      check("abort_rx_level", rx_level, 0);
      check("abort_tx_level", tx_level, 0);
      check("abort_sclk", sclk, 0);
      repeat (3) @(negedge clk);
      check("abort_no_irq", irq_cnt, fd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("sclk_cpol_after_rst", sclk, 1);
      repeat (20) @(negedge clk);
      check("abort_no_irq_after", irq_cnt, fd0);
      check("abort_rx_empty", rx_valid, 0);

      check("irq_count", irq_cnt, frames_done);
      check("queues_empty", frame_q.size() + rx_exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
